fir_mac_seq: RTL and testbench
==============================

# fir_mac_seq

Parametrised, time-multiplexed fixed-point FIR filter engine for the W4823 signal path. It replaces the fixed-configuration FP16 FIR with one multiplier–accumulator that iterates over `TAPS` coefficients per accepted sample. It keeps one independent delay line per channel for `CHANNELS` interleaved channels. A single clock domain uses valid/ready handshakes on input and output, and a coefficient-load port that is honoured only while idle.

## Interface
- `DW`, 16, signed two's-complement sample width (input and output).
- `CW`, 16, signed two's-complement coefficient width.
- `TAPS`, 16, filter length, ≥2.
- `CHANNELS`, 1, number of independent delay lines, ≥1.
- `SHIFT`, 15, arithmetic right shift applied to the accumulator before output.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  DW  input sample.
- `in_ch`  in  max(1,clog2(CHANNELS))  channel of `din`.
- `in_valid`  in  1  `din`/`in_ch` valid.
- `in_ready`  out  1  engine can accept a sample.
- `cin`  in  CW  coefficient value.
- `caddr`  in  clog2(TAPS)  coefficient index k.
- `cload`  in  1  write `cin` to coef[`caddr`].
- `dout`  out  DW  filtered sample.
- `out_ch`  out  width of `in_ch`  channel of `dout`.
- `out_valid`  out  1  `dout` valid, held until taken.
- `out_ready`  in  1  downstream accepts `dout`.

## Operation
- States: IDLE, MAC, ROUND, OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: write `din` at wptr[ch], latch ch, clear acc and k=0, go to MAC.
  - wptr[ch] advances (mod TAPS) on leaving ROUND.
- MAC:
  - Per cycle: acc += coef[k] × x[ch][(wptr[ch]−k) mod TAPS], k++.
  - Leave to ROUND after k=TAPS−1.
  - Pointer wrap from 0 to TAPS−1 is exact modular arithmetic; TAPS need not be a power of two.
- Accumulator:
  - ACC_W = DW+CW+clog2(TAPS), full precision, no overflow is possible.
- ROUND:
  - r = (acc + (SHIFT>0 ? 1<<(SHIFT−1) : 0)) >>> SHIFT, i.e. round half up.
  - r reduced to DW bits per Configuration; register `dout` and `out_ch`, set `out_valid`, go to OUT.
- OUT:
  - `dout`/`out_ch`/`out_valid` held stable.
  - On `out_ready`: `out_valid`=0, go to IDLE.
- Coefficient load:
  - `cload` is written only in IDLE.
  - `cload` in any other state is ignored, not deferred.
  - `cload` and `in_valid` in the same IDLE cycle: the coefficient is written first and is used by that sample.
- `in_ch` ≥ CHANNELS: the sample is accepted and mapped to channel 0.
- Reset (any state, including mid-MAC):
  - State→IDLE; all delay lines, all wptr, all coefficients and acc cleared to 0.
  - Outputs: `in_ready`=0 while `rst` is high, 1 on the first cycle after; `out_valid`=0; `dout`=0; `out_ch`=0.
  - An in-flight sample is discarded.

## Timing
- Acceptance edge E0; MAC occupies edges E1..E_TAPS.
- ROUND is at E_TAPS+1; `out_valid` rises after E_TAPS+1, i.e. latency TAPS+1 cycles.
- Output handshake at edge Eo; `in_ready` is high in the following cycle.
- With `out_ready` tied high, throughput is one sample per TAPS+3 cycles.
- No combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `FIR_SAT_EN` defined: r is clamped to [−2^(DW−1), 2^(DW−1)−1].
- `FIR_SAT_EN` undefined: r is truncated to its low DW bits (two's-complement wrap).

## Structure
- Shared package `fir_pkg`:
  - State enum.
  - ACC_W computation function.
  - Saturation bound constants derived from DW.
- Sub-module `fir_round_sat`:
  - Combinational shift, round and saturate/wrap from ACC_W to DW.
  - Contains the only `FIR_SAT_EN` conditional.
- Delay lines and coefficients are flop arrays; no RAM macro.

## Test plan
- Impulse, TAPS=4, SHIFT=0, coef={1,2,3,4}: input 1,0,0,0,0 on ch0 → `dout` 1,2,3,4,0; `out_valid` 5 cycles after each acceptance.
- Channel isolation, CHANNELS=2, same coefs: ch0=1, ch1=10, ch0=0, ch1=0 → 1, 10, 2, 20 with matching `out_ch`.
- Overflow, DW=CW=16, SHIFT=0, all coef=0x7FFF, four inputs of 0x7FFF:
  - With `FIR_SAT_EN`, final output = 0x7FFF.
  - Without it, final output = low 16 bits of 4×0x3FFF0001 = 0x0004.
- Rounding, SHIFT=1, coef={1,0,0,0}: input 3 → 2; input −3 → −1.
- Backpressure: hold `out_ready`=0 for 10 cycles → `dout`/`out_valid` stable, `in_ready`=0 throughout; `cload` pulsed meanwhile leaves the coefficient unchanged.
- Reset at MAC k=2 → `out_valid` never asserts for that sample; following impulse produces all-zero output, because coefs are cleared.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR engine:
// FSM state encoding, accumulator width and saturation bounds.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } fir_state_t;

  // Full-precision accumulator width: product width plus enough guard
  // bits to sum TAPS products without overflow.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Largest value representable in a dw-bit two's-complement sample.
  function automatic longint sat_max(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  // Most negative value representable in a dw-bit two's-complement sample.
  function automatic longint sat_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: round-half-up arithmetic shift of the
// accumulator, then reduction to DW bits.
// Build option: define FIR_SAT_EN to clamp to the DW-bit signed range;
// without it the result wraps (low DW bits kept).
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ACC_W = 36,
  parameter int SHIFT = 15
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [DW-1:0]    r
);

  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W + 1)'(1) << RSH) : '0;

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  // Add half an output LSB (one extra bit of headroom) and shift arithmetically.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + RND;
    shifted = sum >>> SHIFT;
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(sat_max(DW));
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(sat_min(DW));

  // Clamp the shifted value into the representable output range.
  always_comb begin
    if (shifted > SAT_HI) begin
      r = SAT_HI[DW-1:0];
    end else if (shifted < SAT_LO) begin
      r = SAT_LO[DW-1:0];
    end else begin
      r = shifted[DW-1:0];
    end
  end
`else
  // Two's-complement wrap: keep only the low DW bits.
  always_comb begin
    r = shifted[DW-1:0];
  end
`endif

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR filter: one multiply-accumulate per cycle over TAPS
// coefficients, with an independent delay line per channel.
// Build option FIR_SAT_EN (see fir_round_sat) selects saturating output.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter  int DW       = 16,
  parameter  int CW       = 16,
  parameter  int TAPS     = 16,
  parameter  int CHANNELS = 1,
  parameter  int SHIFT    = 15,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int KW       = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     din,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     cin,
  input  logic [KW-1:0]     caddr,
  input  logic              cload,
  output logic [DW-1:0]     dout,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int ACC_W = acc_width(DW, CW, TAPS);
  localparam int PW    = DW + CW;

  fir_state_t state, next_state;

  logic signed [DW-1:0]    dline [CHANNELS][TAPS];
  logic        [KW-1:0]    wptr  [CHANNELS];
  logic signed [CW-1:0]    coef  [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic        [KW-1:0]    k;
  logic        [CH_W-1:0]  cur_ch;
  logic        [CH_W-1:0]  sel_ch;
  logic        [KW:0]      diff;
  logic        [KW-1:0]    rd_idx;
  logic signed [PW-1:0]    prod;
  logic        [DW-1:0]    r;

  // Out-of-range channel numbers fold onto channel 0.
  always_comb begin
    sel_ch = (int'(in_ch) < CHANNELS) ? in_ch : '0;
  end

  // Tap address (wptr - k) mod TAPS; exact for non-power-of-two TAPS.
  always_comb begin
    diff = {1'b0, wptr[cur_ch]} - {1'b0, k};
    if (diff[KW]) begin
      rd_idx = KW'(diff + (KW + 1)'(TAPS));
    end else begin
      rd_idx = diff[KW-1:0];
    end
    prod = coef[k] * dline[cur_ch][rd_idx];
  end

  fir_round_sat #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_round (
    .acc (acc),
    .r   (r)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; in_ready is held low while reset is asserted.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) next_state = MAC;
      end
      MAC: begin
        if (k == KW'(TAPS - 1)) next_state = ROUND;
      end
      ROUND: begin
        next_state = OUT;
      end
      OUT: begin
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: coefficient/delay-line writes, MAC loop and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) dline[c][t] <= '0;
      end
      for (int t = 0; t < TAPS; t++) coef[t] <= '0;
      acc       <= '0;
      k         <= '0;
      cur_ch    <= '0;
      dout      <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cload && (int'(caddr) < TAPS)) coef[caddr] <= cin;
          if (in_valid) begin
            dline[sel_ch][wptr[sel_ch]] <= din;
            cur_ch <= sel_ch;
            acc    <= '0;
            k      <= '0;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
          k   <= k + 1'b1;
        end
        ROUND: begin
          dout      <= r;
          out_ch    <= cur_ch;
          out_valid <= 1'b1;
          wptr[cur_ch] <= (wptr[cur_ch] == KW'(TAPS - 1)) ? '0 : wptr[cur_ch] + 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed testbench for fir_mac_seq. Two instances (SHIFT=0 and SHIFT=1,
// TAPS=4, CHANNELS=2) share every input so they run in lock step; the
// second one exercises rounding. Overflow expectations depend on FIR_SAT_EN.
module tb_fir_mac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        in_ch;
  logic        in_valid;
  logic [15:0] cin;
  logic [1:0]  caddr;
  logic        cload;
  logic        out_ready;

  logic        in_ready0, in_ready1;
  logic [15:0] dout0, dout1;
  logic        out_ch0, out_ch1;
  logic        out_valid0, out_valid1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fir_mac_seq #(.DW(16), .CW(16), .TAPS(4), .CHANNELS(2), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(in_ready0), .cin(cin), .caddr(caddr), .cload(cload),
    .dout(dout0), .out_ch(out_ch0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  fir_mac_seq #(.DW(16), .CW(16), .TAPS(4), .CHANNELS(2), .SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(in_ready1), .cin(cin), .caddr(caddr), .cload(cload),
    .dout(dout1), .out_ch(out_ch1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic loadCoefs(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3);
    logic [15:0] c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < 4; i++) begin
      cload = 1'b1;
      caddr = 2'(i);
      cin   = c[i];
      @(posedge clk); #1;
    end
    cload = 1'b0;
  endtask

  // Send one sample, check latency and both outputs, optionally hold
  // out_ready low for 'hold' cycles (pulsing cload meanwhile), then take it.
  task automatic applyStimulus(input string tag, input logic ch, input logic [15:0] x,
                               input logic [15:0] e0, input logic [15:0] e1,
                               input int hold, input bit ld, input logic [15:0] lc);
    int n;
    int lat;
    n = 0;
    while (!in_ready0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_in_ready"}, 32'(in_ready0), 32'd1);
    in_valid = 1'b1;
    din      = x;
    in_ch    = ch;
    if (ld) begin
      cload = 1'b1;
      caddr = 2'd0;
      cin   = lc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cload    = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd5);
    checkOutput({tag, "_dout0"}, 32'(dout0), 32'(e0));
    checkOutput({tag, "_dout1"}, 32'(dout1), 32'(e1));
    checkOutput({tag, "_out_ch"}, 32'(out_ch0), 32'(ch));
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        cload = 1'b1;
        caddr = 2'd0;
        cin   = 16'd7;
      end
      @(posedge clk); #1;
      cload = 1'b0;
      checkOutput({tag, "_hold_valid"}, 32'(out_valid0), 32'd1);
      checkOutput({tag, "_hold_dout"}, 32'(dout0), 32'(e0));
      checkOutput({tag, "_hold_in_ready"}, 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid0), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(in_ready0), 32'd1);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput({tag, "_in_ready"}, 32'(in_ready0), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid0), 32'd0);
    checkOutput({tag, "_dout"}, 32'(dout0), 32'd0);
    checkOutput({tag, "_out_ch"}, 32'(out_ch0), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput({tag, "_ready_after"}, 32'(in_ready0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic seen;
    logic [15:0] ov0 [4];
    logic [15:0] ov1 [4];
    rst = 1'b1; din = '0; in_ch = 1'b0; in_valid = 1'b0;
    cin = '0; caddr = '0; cload = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    doReset("reset");

    // Impulse response with coef {1,2,3,4}.
    loadCoefs(16'd1, 16'd2, 16'd3, 16'd4);
    applyStimulus("imp0", 1'b0, 16'd1, 16'd1, 16'd1, 0, 1'b0, 16'd0);
    applyStimulus("imp1", 1'b0, 16'd0, 16'd2, 16'd1, 0, 1'b0, 16'd0);
    applyStimulus("imp2", 1'b0, 16'd0, 16'd3, 16'd2, 0, 1'b0, 16'd0);
    applyStimulus("imp3", 1'b0, 16'd0, 16'd4, 16'd2, 0, 1'b0, 16'd0);
    applyStimulus("imp4", 1'b0, 16'd0, 16'd0, 16'd0, 0, 1'b0, 16'd0);

    // Channel isolation.
    applyStimulus("ch_a", 1'b0, 16'd1,  16'd1,  16'd1,  0, 1'b0, 16'd0);
    applyStimulus("ch_b", 1'b1, 16'd10, 16'd10, 16'd5,  0, 1'b0, 16'd0);
    applyStimulus("ch_c", 1'b0, 16'd0,  16'd2,  16'd1,  0, 1'b0, 16'd0);
    applyStimulus("ch_d", 1'b1, 16'd0,  16'd20, 16'd10, 0, 1'b0, 16'd0);

    // Rounding with coef {1,0,0,0}.
    loadCoefs(16'd1, 16'd0, 16'd0, 16'd0);
    applyStimulus("rnd_p3", 1'b0, 16'd3,     16'd3,     16'd2,     0, 1'b0, 16'd0);
    applyStimulus("rnd_m3", 1'b0, 16'hFFFD,  16'hFFFD,  16'hFFFF,  0, 1'b0, 16'd0);

    // Coefficient written in the same cycle as the sample is used by it.
    applyStimulus("ld_same", 1'b0, 16'd2, 16'd10, 16'd5, 0, 1'b1, 16'd5);

    // Backpressure with cload pulse ignored, then confirm coef unchanged.
    applyStimulus("bp",      1'b1, 16'd1, 16'd5, 16'd3, 10, 1'b0, 16'd0);
    applyStimulus("bp_coef", 1'b1, 16'd1, 16'd5, 16'd3, 0,  1'b0, 16'd0);

    // Overflow: all coefs and inputs 0x7FFF, after a clean reset.
    doReset("reset2");
`ifdef FIR_SAT_EN
    ov0[0] = 16'h7FFF; ov0[1] = 16'h7FFF; ov0[2] = 16'h7FFF; ov0[3] = 16'h7FFF;
    ov1[0] = 16'h7FFF; ov1[1] = 16'h7FFF; ov1[2] = 16'h7FFF; ov1[3] = 16'h7FFF;
`else
    ov0[0] = 16'h0001; ov0[1] = 16'h0002; ov0[2] = 16'h0003; ov0[3] = 16'h0004;
    ov1[0] = 16'h8001; ov1[1] = 16'h0001; ov1[2] = 16'h8002; ov1[3] = 16'h0002;
`endif
    loadCoefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("ovf%0d", i), 1'b0, 16'h7FFF, ov0[i], ov1[i], 0, 1'b0, 16'd0);
    end

    // Reset in the middle of MAC (k=2): sample discarded, coefs cleared.
    loadCoefs(16'd1, 16'd2, 16'd3, 16'd4);
    in_valid = 1'b1;
    din      = 16'd1;
    in_ch    = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("midrst_in_ready", 32'(in_ready0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) seen = 1'b1;
    end
    checkOutput("midrst_no_out", 32'(seen), 32'd0);
    applyStimulus("post_rst0", 1'b0, 16'd1,     16'd0, 16'd0, 0, 1'b0, 16'd0);
    applyStimulus("post_rst1", 1'b1, 16'h7FFF,  16'd0, 16'd0, 0, 1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
